// File: rtl/alu_vector_sequencer.sv
// Purpose : self-test sweep controller for the 32-bit ALU + 7-segment display board.
// Latency : LOAD 1 cycle, DWELL DWELL_CYCLES cycles (auto) or until a step edge (manual), ADVANCE 1 cycle.
// Backpressure: none; pause_i freezes the auto dwell counter, abort_i returns to IDLE.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_i, step_i            level inputs; rising edges start/restart the sweep or step it (manual)
//   mode_i                     0 = auto advance after DWELL_CYCLES, 1 = manual advance on step edge
//   pause_i, abort_i           freeze dwell counter (auto) / synchronous return to IDLE
//   addra_o, addrb_o           operand memory addresses
//   operacion_o, c_o, invert_o ALU operation code, carry-in, B-invert
//   valid_o, busy_o, done_o    vector displayable / sweep running / sweep finished
//   index_o                    linear vector index {op_idx, addra, addrb}
module alu_vector_sequencer #(
    parameter int unsigned        DWELL_CYCLES = 50000000,
    parameter int unsigned        N_OPS        = 4,
    parameter logic [4*N_OPS-1:0] OP_LIST      = {4'b0110, 4'b0010, 4'b0001, 4'b0000}
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       step_i,
    input  logic       pause_i,
    input  logic       abort_i,
    output logic [2:0] addra_o,
    output logic [2:0] addrb_o,
    output logic [3:0] operacion_o,
    output logic       c_o,
    output logic       invert_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [8:0] index_o
);

    // A one-cycle dwell still needs a 1-bit counter so the compare stays well formed.
    localparam int unsigned      CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]       OP_LAST  = 3'(N_OPS - 1);
    localparam logic [8:0]       IDX_LAST = {OP_LAST, 6'h3F};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DWELL,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_start_prev;
    logic             r_step_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op_idx;
    logic [2:0]       r_addra;
    logic [2:0]       r_addrb;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [8:0]       w_idx;
    logic [8:0]       w_idx_nxt;
    logic             w_start_edge;
    logic             w_step_edge;
    logic             w_last;
    logic [3:0]       w_op;

    assign w_start_edge = start_i & ~r_start_prev;
    assign w_step_edge  = step_i & ~r_step_prev;

    // addrb is the innermost loop, so a plain +1 on the concatenation carries
    // addrb -> addra -> op_idx in the required order.
    assign w_idx  = {r_op_idx, r_addra, r_addrb};
    assign w_last = (w_idx == IDX_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b0;
            r_step_prev  <= 1'b0;
            r_cnt        <= '0;
            r_op_idx     <= 3'd0;
            r_addra      <= 3'd0;
            r_addrb      <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_prev <= start_i;
            r_step_prev  <= step_i;
            r_cnt        <= w_cnt_nxt;
            r_op_idx     <= w_idx_nxt[8:6];
            r_addra      <= w_idx_nxt[5:3];
            r_addrb      <= w_idx_nxt[2:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: abort, then start edge, then per-state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = w_idx;

        if (abort_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 9'd0;
        end else if (w_start_edge) begin
            // Start from any state (including DONE) restarts at vector 0.
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 9'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_LOAD: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DWELL;
                end
                S_DWELL: begin
                    if (mode_i) begin
                        // Manual: counter untouched so it survives a switch back to auto.
                        if (w_step_edge) begin
                            w_state_nxt = S_ADVANCE;
                        end
                    end else if (!pause_i) begin
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = S_ADVANCE;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                S_ADVANCE: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = w_idx + 9'd1;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 9'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operation lookup and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_op = 4'd0;
        for (int k = 0; k < int'(N_OPS); k++) begin
            if (r_op_idx == 3'(k)) begin
                w_op = OP_LIST[4*k +: 4];
            end
        end
    end

    // In IDLE every output reads 0, so the op code is masked there; the
    // indices are already 0 because reset and abort clear them.
    assign operacion_o = (r_state == S_IDLE) ? 4'd0 : w_op;
    assign c_o         = operacion_o[2];
    assign invert_o    = operacion_o[2];
    assign addra_o     = r_addra;
    assign addrb_o     = r_addrb;
    assign index_o     = w_idx;

    assign valid_o = (r_state == S_DWELL) || (r_state == S_DONE);
    assign busy_o  = (r_state == S_LOAD) || (r_state == S_DWELL) || (r_state == S_ADVANCE);
    assign done_o  = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Purpose : directed bench for alu_vector_sequencer (DWELL_CYCLES=4, N_OPS=2, ops ADD then SUB).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable; every wait on the DUT is bounded.
module tb_alu_vector_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       mode_i;
    logic       step_i;
    logic       pause_i;
    logic       abort_i;
    logic [2:0] addra_o;
    logic [2:0] addrb_o;
    logic [3:0] operacion_o;
    logic       c_o;
    logic       invert_o;
    logic       valid_o;
    logic       busy_o;
    logic       done_o;
    logic [8:0] index_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_vector_sequencer #(
        .DWELL_CYCLES(4),
        .N_OPS       (2),
        .OP_LIST     ({4'b0110, 4'b0010})
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .step_i     (step_i),
        .pause_i    (pause_i),
        .abort_i    (abort_i),
        .addra_o    (addra_o),
        .addrb_o    (addrb_o),
        .operacion_o(operacion_o),
        .c_o        (c_o),
        .invert_o   (invert_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .index_o    (index_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the given index is displayed with valid_o high.
    task automatic wait_idx(input logic [8:0] t, input string tag);
        int n = 0;
        while (!(index_o == t && valid_o) && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 1000), 32'd1);
    endtask

    initial begin
        int         load0;
        int         vcount;
        int         guard;
        logic       seen64;
        logic       idx_moved;
        logic [3:0] prev_op;

        rst_n   = 1'b0;
        start_i = 1'b0;
        mode_i  = 1'b0;
        step_i  = 1'b0;
        pause_i = 1'b0;
        abort_i = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_done",  32'(done_o), 32'd0);
        chk("rst_index", 32'(index_o), 32'd0);
        chk("rst_op",    32'(operacion_o), 32'd0);
        chk("rst_c",     32'(c_o), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // ---------------- first vector in auto mode ----------------
        start_i = 1'b1;
        tick();
        load0   = cyc;
        start_i = 1'b0;
        chk("load0_valid", 32'(valid_o), 32'd0);
        chk("load0_busy",  32'(busy_o), 32'd1);
        chk("load0_index", 32'(index_o), 32'd0);
        chk("load0_op",    32'(operacion_o), 32'h2);
        chk("load0_c",     32'(c_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dwell0_valid", 32'(valid_o), 32'd1);
        end
        tick();
        chk("adv0_valid", 32'(valid_o), 32'd0);
        chk("adv0_busy",  32'(busy_o), 32'd1);
        tick();
        chk("load1_index", 32'(index_o), 32'd1);
        chk("load1_valid", 32'(valid_o), 32'd0);

        // ---------------- addrb inner, addra outer ----------------
        for (int v = 1; v <= 8; v++) begin
            chk("seq_index", 32'(index_o), 32'(v));
            chk("seq_addrb", 32'(addrb_o), 32'(v % 8));
            chk("seq_addra", 32'(addra_o), 32'(v / 8));
            tick();
            tick();
            tick();
            tick();
            tick();
            tick();
        end

        // ---------------- rest of the full sweep ----------------
        seen64  = 1'b0;
        prev_op = 4'd0;
        guard   = 0;
        while (!done_o && guard < 2000) begin
            tick();
            guard++;
            if (index_o == 9'd63) prev_op = operacion_o;
            if (index_o == 9'd64 && !seen64) begin
                seen64 = 1'b1;
                chk("op_before_64", 32'(prev_op), 32'h2);
                chk("op_at_64",     32'(operacion_o), 32'h6);
                chk("c_at_64",      32'(c_o), 32'd1);
                chk("inv_at_64",    32'(invert_o), 32'd1);
            end
        end
        chk("sweep_seen64",  32'(seen64), 32'd1);
        chk("sweep_done",    32'(done_o), 32'd1);
        chk("sweep_cycles",  32'(cyc - load0), 32'd768);
        chk("final_addra",   32'(addra_o), 32'd7);
        chk("final_addrb",   32'(addrb_o), 32'd7);
        chk("final_op",      32'(operacion_o), 32'h6);
        chk("final_c",       32'(c_o), 32'd1);
        chk("final_inv",     32'(invert_o), 32'd1);
        chk("final_index",   32'(index_o), 32'd127);
        chk("final_busy",    32'(busy_o), 32'd0);
        chk("final_valid",   32'(valid_o), 32'd1);
        tick();
        tick();
        chk("done_hold", 32'(done_o), 32'd1);

        // ---------------- pause stretches the dwell ----------------
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_done",  32'(done_o), 32'd0);
        chk("restart_index", 32'(index_o), 32'd0);
        vcount = 0;
        tick();
        if (valid_o) vcount++;
        tick();
        if (valid_o) vcount++;
        pause_i   = 1'b1;
        idx_moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_o) vcount++;
            if (index_o != 9'd0) idx_moved = 1'b1;
        end
        pause_i = 1'b0;
        guard   = 0;
        while (valid_o && guard < 20) begin
            tick();
            guard++;
            if (valid_o) vcount++;
            if (valid_o && index_o != 9'd0) idx_moved = 1'b1;
        end
        chk("pause_window", 32'(vcount), 32'd14);
        chk("pause_index",  32'(idx_moved), 32'd0);
        tick();
        chk("pause_next", 32'(index_o), 32'd1);

        // ---------------- manual mode ----------------
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        mode_i  = 1'b1;
        idx_moved = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (index_o != 9'd0 || !valid_o) idx_moved = 1'b1;
        end
        chk("manual_hold", 32'(idx_moved), 32'd0);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        chk("manual_adv_valid", 32'(valid_o), 32'd0);
        tick();
        tick();
        tick();
        chk("manual_step1", 32'(index_o), 32'd1);
        chk("manual_step1_valid", 32'(valid_o), 32'd1);
        step_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        step_i = 1'b0;
        tick();
        tick();
        chk("manual_held_step", 32'(index_o), 32'd2);
        chk("manual_held_valid", 32'(valid_o), 32'd1);

        // ---------------- async reset mid-dwell ----------------
        mode_i  = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_idx(9'd37, "wait_idx37");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_index", 32'(index_o), 32'd0);
        chk("arst_busy",  32'(busy_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_op",    32'(operacion_o), 32'd0);
        chk("arst_addra", 32'(addra_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", 32'(busy_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("arst_start_index", 32'(index_o), 32'd0);
        chk("arst_start_busy",  32'(busy_o), 32'd1);

        // ---------------- restart during vector 20 ----------------
        wait_idx(9'd20, "wait_idx20");
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart20_index", 32'(index_o), 32'd0);
        chk("restart20_valid", 32'(valid_o), 32'd0);
        chk("restart20_busy",  32'(busy_o), 32'd1);

        // ---------------- abort beats start ----------------
        tick();
        tick();
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_busy",  32'(busy_o), 32'd0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_index", 32'(index_o), 32'd0);
        chk("abort_op",    32'(operacion_o), 32'd0);
        tick();
        chk("abort_stay_idle", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
